la_iopwrseq: RTL and testbench

LA_IOPWRSEQ -- requirements
Module: la_iopwrseq

---
 rtl/la_iolib_pkg.sv | 39 +++
 rtl/la_iopwrseq_cnt.sv | 40 ++++
 rtl/la_iopwrseq.sv | 207 ++++++++++++++++++++
 tb/tb_la_iopwrseq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_iolib_pkg.sv
//------------------------------------------------------------------------------
// la_iolib_pkg
// Shared definitions for io ring controllers: power sequencer state encoding,
// ioring control bit positions and a small state classification helper.
// No ports (package).
//------------------------------------------------------------------------------
package la_iolib_pkg;

   // Power sequencer state encoding, kept as plain 3-bit constants so other
   // ring controllers can decode a sequencer state bus without the enum.
   localparam logic [2:0] PWR_OFF    = 3'd0;
   localparam logic [2:0] PWR_RAMPUP = 3'd1;
   localparam logic [2:0] PWR_WAITPG = 3'd2;
   localparam logic [2:0] PWR_ON     = 3'd3;
   localparam logic [2:0] PWR_RAMPDN = 3'd4;
   localparam logic [2:0] PWR_FAULT  = 3'd5;

   typedef enum logic [2:0] {
      S_OFF    = PWR_OFF,
      S_RAMPUP = PWR_RAMPUP,
      S_WAITPG = PWR_WAITPG,
      S_ON     = PWR_ON,
      S_RAMPDN = PWR_RAMPDN,
      S_FAULT  = PWR_FAULT
   } pwr_state_t;

   // ioring control bit positions
   localparam int IORING_READY = 0;
   localparam int IORING_ISO   = 1;

   // A sequencer is busy while any supply is ramping in either direction.
   function automatic logic pwr_busy(input pwr_state_t s);
      case (s)
         S_RAMPUP, S_WAITPG, S_RAMPDN: pwr_busy = 1'b1;
         default:                      pwr_busy = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/la_iopwrseq_cnt.sv
//------------------------------------------------------------------------------
// la_iopwrseq_cnt
// Loadable down-counter used for settle delays and power-good timeouts.
// Ports:
//   clk    - clock
//   nreset - synchronous active-low reset (count -> 0)
//   load   - load din (has priority over dec)
//   dec    - decrement by one; holds at zero
//   din    - load value
//   zero   - count is zero
//------------------------------------------------------------------------------
module la_iopwrseq_cnt #(
   parameter int DLYW = 8
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            load,
   input  logic            dec,
   input  logic [DLYW-1:0] din,
   output logic            zero
);

   logic [DLYW-1:0] cnt_r;

   // count register: load wins over decrement, never wraps below zero
   always_ff @(posedge clk) begin
      if (!nreset) begin
         cnt_r <= {DLYW{1'b0}};
      end else if (load) begin
         cnt_r <= din;
      end else if (dec && (cnt_r != {DLYW{1'b0}})) begin
         cnt_r <= cnt_r - DLYW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {DLYW{1'b0}});

endmodule

// File: rtl/la_iopwrseq.sv
//------------------------------------------------------------------------------
// la_iopwrseq
// IO supply power sequencer. Turns io supply segments on one at a time
// (settle delay, then wait for power-good with timeout) and off in reverse
// order. Power-good loss or timeout drops every segment and latches fault
// until the request is withdrawn.
// Ports:
//   clk     - clock
//   nreset  - synchronous active-low reset
//   en      - 1: power-up request, 0: power-down request
//   dly     - settle delay in cycles (sampled at each counter load)
//   tmo     - power-good timeout in cycles (sampled at each counter load)
//   pg      - per-segment power-good
//   seg_en  - per-segment supply switch enable
//   ready   - all segments on and good
//   busy    - ramping up or down
//   fault   - timeout or power-good loss
//   ioring  - ring control: [0]=ready, [1]=iso (~ready), others 0
//------------------------------------------------------------------------------
module la_iopwrseq
   import la_iolib_pkg::*;
#(
   parameter     PROP  = "DEFAULT",
   parameter     SIDE  = "NO",
   parameter int RINGW = 8,
   parameter int NSEG  = 4,
   parameter int DLYW  = 8
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             en,
   input  logic [DLYW-1:0]  dly,
   input  logic [DLYW-1:0]  tmo,
   input  logic [NSEG-1:0]  pg,
   output logic [NSEG-1:0]  seg_en,
   output logic             ready,
   output logic             busy,
   output logic             fault,
   output logic [RINGW-1:0] ioring
);

   localparam int              IDXW     = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSEG - 1);
   localparam logic [RINGW-1:0] RING_RST = RINGW'(1) << IORING_ISO;

   pwr_state_t       state_r, state_s;
   logic [IDXW-1:0]  idx_r, idx_s;
   logic [NSEG-1:0]  seg_en_r, seg_en_s;
   logic             ready_r, ready_s;
   logic             busy_r, busy_s;
   logic             fault_r, fault_s;
   logic [RINGW-1:0] ioring_r, ioring_s;
   logic             cnt_load_s, cnt_dec_s, cnt_zero_s;
   logic [DLYW-1:0]  cnt_din_s;

   la_iopwrseq_cnt #(.DLYW(DLYW)) u_cnt (
      .clk    (clk),
      .nreset (nreset),
      .load   (cnt_load_s),
      .dec    (cnt_dec_s),
      .din    (cnt_din_s),
      .zero   (cnt_zero_s)
   );

   // next state, segment enables and counter control
   always_comb begin
      state_s    = state_r;
      idx_s      = idx_r;
      seg_en_s   = seg_en_r;
      fault_s    = 1'b0;
      cnt_load_s = 1'b0;
      cnt_dec_s  = 1'b0;
      cnt_din_s  = dly;
      case (state_r)
         S_OFF: begin
            seg_en_s = {NSEG{1'b0}};
            idx_s    = IDX_ZERO;
            if (en) begin
               state_s     = S_RAMPUP;
               seg_en_s[0] = 1'b1;
               cnt_load_s  = 1'b1;
            end else begin
               state_s = S_OFF;
            end
         end
         S_RAMPUP: begin
            // a withdrawn request unwinds from the segment being ramped
            if (!en) begin
               state_s          = S_RAMPDN;
               seg_en_s[idx_r]  = 1'b0;
               cnt_load_s       = 1'b1;
            end else if (cnt_zero_s) begin
               state_s    = S_WAITPG;
               cnt_load_s = 1'b1;
               cnt_din_s  = tmo;
            end else begin
               cnt_dec_s = 1'b1;
            end
         end
         S_WAITPG: begin
            if (!en) begin
               state_s         = S_RAMPDN;
               seg_en_s[idx_r] = 1'b0;
               cnt_load_s      = 1'b1;
            end else if (pg[idx_r]) begin
               if (idx_r == IDX_LAST) begin
                  state_s = S_ON;
               end else begin
                  state_s         = S_RAMPUP;
                  idx_s           = idx_r + IDX_ONE;
                  seg_en_s[idx_s] = 1'b1;
                  cnt_load_s      = 1'b1;
               end
            end else if (cnt_zero_s) begin
               state_s  = S_FAULT;
               seg_en_s = {NSEG{1'b0}};
               fault_s  = 1'b1;
            end else begin
               cnt_dec_s = 1'b1;
            end
         end
         S_ON: begin
            seg_en_s = {NSEG{1'b1}};
            // supply loss outranks a power-down request
            if (!(&pg)) begin
               state_s  = S_FAULT;
               seg_en_s = {NSEG{1'b0}};
               fault_s  = 1'b1;
            end else if (!en) begin
               state_s            = S_RAMPDN;
               idx_s              = IDX_LAST;
               seg_en_s[IDX_LAST] = 1'b0;
               cnt_load_s         = 1'b1;
            end else begin
               state_s = S_ON;
            end
         end
         S_RAMPDN: begin
            // en is deliberately ignored: ramp-down always completes
            if (cnt_zero_s) begin
               if (idx_r == IDX_ZERO) begin
                  state_s = S_OFF;
               end else begin
                  idx_s           = idx_r - IDX_ONE;
                  seg_en_s[idx_s] = 1'b0;
                  cnt_load_s      = 1'b1;
               end
            end else begin
               cnt_dec_s = 1'b1;
            end
         end
         S_FAULT: begin
            seg_en_s = {NSEG{1'b0}};
            if (!en) begin
               state_s = S_OFF;
               idx_s   = IDX_ZERO;
            end else begin
               fault_s = 1'b1;
            end
         end
         default: begin
            state_s  = S_OFF;
            idx_s    = IDX_ZERO;
            seg_en_s = {NSEG{1'b0}};
         end
      endcase
   end

   // status outputs follow the next state so they change on the same edge
   always_comb begin
      ready_s                = (state_s == S_ON);
      busy_s                 = pwr_busy(state_s);
      ioring_s               = {RINGW{1'b0}};
      ioring_s[IORING_READY] = ready_s;
      ioring_s[IORING_ISO]   = ~ready_s;
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_r  <= S_OFF;
         idx_r    <= IDX_ZERO;
         seg_en_r <= {NSEG{1'b0}};
         ready_r  <= 1'b0;
         busy_r   <= 1'b0;
         fault_r  <= 1'b0;
         ioring_r <= RING_RST;
      end else begin
         state_r  <= state_s;
         idx_r    <= idx_s;
         seg_en_r <= seg_en_s;
         ready_r  <= ready_s;
         busy_r   <= busy_s;
         fault_r  <= fault_s;
         ioring_r <= ioring_s;
      end
   end

   assign seg_en = seg_en_r;
   assign ready  = ready_r;
   assign busy   = busy_r;
   assign fault  = fault_r;
   assign ioring = ioring_r;

endmodule

// File: tb/tb_la_iopwrseq.sv
//------------------------------------------------------------------------------
// tb_la_iopwrseq
// Bench for la_iopwrseq (NSEG=4, RINGW=8, DLYW=8). Each segment's power-good
// follows its enable with a per-segment lag; expected output timelines are
// computed from event times (settle = dly+1 cycles, then power-good seen at
// max(dly+2, lag) cycles after the enable, or timeout at dly+2+tmo).
//------------------------------------------------------------------------------
module tb_la_iopwrseq;

   localparam int NSEG  = 4;
   localparam int RINGW = 8;
   localparam int DLYW  = 8;
   localparam int NEVER = 1000;

   logic             clk = 1'b0;
   logic             nreset;
   logic             en;
   logic [DLYW-1:0]  dly;
   logic [DLYW-1:0]  tmo;
   logic [NSEG-1:0]  pg;
   logic [NSEG-1:0]  seg_en;
   logic             ready;
   logic             busy;
   logic             fault;
   logic [RINGW-1:0] ioring;

   int vectors     = 0;
   int miscompares = 0;

   int              lag [NSEG];
   logic [NSEG-1:0] hist [$];
   logic [NSEG-1:0] pg_kill = 4'b0000;

   always #5 clk = ~clk;

   la_iopwrseq #(.PROP("DEFAULT"), .SIDE("NO"), .RINGW(RINGW), .NSEG(NSEG), .DLYW(DLYW)) dut (
      .clk    (clk),
      .nreset (nreset),
      .en     (en),
      .dly    (dly),
      .tmo    (tmo),
      .pg     (pg),
      .seg_en (seg_en),
      .ready  (ready),
      .busy   (busy),
      .fault  (fault),
      .ioring (ioring)
   );

   // one clock; afterwards drive pg as the lagged copy of seg_en
   task automatic tick();
      logic [NSEG-1:0] h;
      logic [NSEG-1:0] p;
      @(posedge clk);
      #1;
      hist.push_front(seg_en);
      if (hist.size() > 64) void'(hist.pop_back());
      p = 4'b0000;
      for (int k = 0; k < NSEG; k++) begin
         if (lag[k] >= 1 && lag[k] <= hist.size()) begin
            h    = hist[lag[k]-1];
            p[k] = h[k];
         end
      end
      pg = p & ~pg_kill;
   endtask

   task automatic test_reset();
      logic [14:0] exp_v;
      exp_v = {4'b0000, 3'b000, 8'h02};
      nreset = 1'b0; en = 1'b0; dly = 8'd0; tmo = 8'd0; pg = 4'b0000;
      for (int i = 0; i < NSEG; i++) lag[i] = NEVER;
      tick(); tick();
      vectors++;
      if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
         miscompares++;
         $display("FAIL reset act=%h exp=%h", {seg_en, ready, busy, fault, ioring}, exp_v);
      end
      nreset = 1'b1;
      tick();
      vectors++;
      if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
         miscompares++;
         $display("FAIL reset_idle act=%h exp=%h", {seg_en, ready, busy, fault, ioring}, exp_v);
      end
   endtask

   // power-up from OFF; stop_at<0 runs to ON or fault. Edge n=0 samples en=1.
   task automatic run_up(input int d, input int t, input int stop_at, output bit on);
      int rise [NSEG];
      int tt, t_on, t_f, last;
      logic [NSEG-1:0] es;
      logic er, eb, ef;
      logic [14:0] exp_v;
      t_on = -1; t_f = -1; tt = 0;
      for (int k = 0; k < NSEG; k++) rise[k] = 10 * NEVER;
      for (int k = 0; k < NSEG; k++) begin
         rise[k] = tt;
         if (lag[k] <= d + 2 + t) begin
            tt += (lag[k] > d + 2) ? lag[k] : d + 2;
         end else begin
            t_f = tt + d + 2 + t;
            break;
         end
      end
      if (t_f < 0) t_on = tt;
      last = (stop_at >= 0) ? stop_at : ((t_on >= 0) ? t_on : t_f);
      dly = d[7:0]; tmo = t[7:0];
      hist.delete(); pg = 4'b0000; en = 1'b1;
      for (int n = 0; n <= last; n++) begin
         tick();
         if (t_f >= 0 && n >= t_f) begin
            es = 4'b0000; er = 1'b0; eb = 1'b0; ef = 1'b1;
         end else begin
            es = 4'b0000;
            for (int k = 0; k < NSEG; k++) if (rise[k] <= n) es[k] = 1'b1;
            er = (t_on >= 0 && n >= t_on);
            eb = !er; ef = 1'b0;
         end
         exp_v = {es, er, eb, ef, 6'b000000, ~er, er};
         vectors++;
         if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
            miscompares++;
            $display("FAIL up d=%0d t=%0d n=%0d act=%h exp=%h", d, t, n,
                     {seg_en, ready, busy, fault, ioring}, exp_v);
         end
      end
      on = (t_on >= 0);
   endtask

   // power-down from segment top; optional en=1 after edge reassert_at
   task automatic run_dn(input int d, input int top, input int reassert_at);
      int off_t, last;
      logic [NSEG-1:0] es;
      logic eb;
      logic [14:0] exp_v;
      off_t = (top + 1) * (d + 1);
      last  = off_t + ((reassert_at >= 0) ? 1 : 0);
      dly = d[7:0]; en = 1'b0;
      for (int n = 0; n <= last; n++) begin
         tick();
         es = 4'b0000;
         if (n < off_t) begin
            for (int j = 0; j <= top; j++) if (n < (top - j) * (d + 1)) es[j] = 1'b1;
            eb = 1'b1;
         end else if (n == off_t) begin
            eb = 1'b0;
         end else begin
            es = 4'b0001; eb = 1'b1;
         end
         exp_v = {es, 1'b0, eb, 1'b0, 8'h02};
         vectors++;
         if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
            miscompares++;
            $display("FAIL dn d=%0d top=%0d n=%0d act=%h exp=%h", d, top, n,
                     {seg_en, ready, busy, fault, ioring}, exp_v);
         end
         if (n == reassert_at) en = 1'b1;
      end
   endtask

   task automatic test_rampup();
      bit on;
      for (int k = 0; k < NSEG; k++) lag[k] = 2;
      run_up(3, 5, -1, on);
   endtask

   task automatic test_rampdown();
      run_dn(3, NSEG - 1, -1);
   endtask

   task automatic test_timeout();
      bit on;
      logic [14:0] exp_v;
      lag[0] = 1; lag[1] = NEVER; lag[2] = 1; lag[3] = 1;
      run_up(0, 2, -1, on);
      exp_v = {4'b0000, 3'b001, 8'h02};
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
            miscompares++;
            $display("FAIL fault_hold i=%0d act=%h exp=%h", i, {seg_en, ready, busy, fault, ioring}, exp_v);
         end
      end
      en = 1'b0;
      tick();
      exp_v = {4'b0000, 3'b000, 8'h02};
      vectors++;
      if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
         miscompares++;
         $display("FAIL fault_clear act=%h exp=%h", {seg_en, ready, busy, fault, ioring}, exp_v);
      end
   endtask

   task automatic test_pgloss();
      bit on;
      logic [14:0] exp_v;
      for (int k = 0; k < NSEG; k++) lag[k] = 2;
      run_up(1, 5, -1, on);
      pg_kill = 4'b0100;
      pg = pg & ~pg_kill;
      tick();
      pg_kill = 4'b0000;
      exp_v = {4'b0000, 3'b001, 8'h02};
      vectors++;
      if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
         miscompares++;
         $display("FAIL pgloss act=%h exp=%h", {seg_en, ready, busy, fault, ioring}, exp_v);
      end
      tick();
      vectors++;
      if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
         miscompares++;
         $display("FAIL pgloss_hold act=%h exp=%h", {seg_en, ready, busy, fault, ioring}, exp_v);
      end
      en = 1'b0;
      tick();
      exp_v = {4'b0000, 3'b000, 8'h02};
      vectors++;
      if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
         miscompares++;
         $display("FAIL pgloss_clear act=%h exp=%h", {seg_en, ready, busy, fault, ioring}, exp_v);
      end
   endtask

   // en=0 while waiting for segment 2 power-good (entered after edge 14)
   task automatic test_abort();
      bit on;
      lag[0] = 2; lag[1] = 2; lag[2] = 8; lag[3] = 2;
      run_up(3, 5, 15, on);
      run_dn(3, 2, -1);
   endtask

   task automatic test_reassert();
      bit on;
      for (int k = 0; k < NSEG; k++) lag[k] = 2;
      run_up(2, 4, -1, on);
      run_dn(2, NSEG - 1, 5);
      run_dn(2, 0, -1);
   endtask

   task automatic test_reset_mid();
      bit on;
      logic [14:0] exp_v;
      for (int k = 0; k < NSEG; k++) lag[k] = 2;
      run_up(3, 5, 6, on);
      nreset = 1'b0;
      tick();
      exp_v = {4'b0000, 3'b000, 8'h02};
      vectors++;
      if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
         miscompares++;
         $display("FAIL reset_mid act=%h exp=%h", {seg_en, ready, busy, fault, ioring}, exp_v);
      end
      nreset = 1'b1;
      tick();
      exp_v = {4'b0001, 3'b010, 8'h02};
      vectors++;
      if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
         miscompares++;
         $display("FAIL reset_release act=%h exp=%h", {seg_en, ready, busy, fault, ioring}, exp_v);
      end
      run_dn(3, 0, -1);
   endtask

   task automatic test_random();
      bit on;
      int d, t;
      logic [14:0] exp_v;
      for (int r = 0; r < 10; r++) begin
         d = $urandom_range(0, 4);
         t = $urandom_range(0, 5);
         for (int k = 0; k < NSEG; k++)
            lag[k] = ($urandom_range(0, 6) == 0) ? NEVER : $urandom_range(1, 9);
         run_up(d, t, -1, on);
         if (on) begin
            run_dn($urandom_range(0, 4), NSEG - 1, -1);
         end else begin
            en = 1'b0;
            tick();
            exp_v = {4'b0000, 3'b000, 8'h02};
            vectors++;
            if ({seg_en, ready, busy, fault, ioring} !== exp_v) begin
               miscompares++;
               $display("FAIL rnd_clear r=%0d act=%h exp=%h", r, {seg_en, ready, busy, fault, ioring}, exp_v);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rampup();
      test_rampdown();
      test_timeout();
      test_pgloss();
      test_abort();
      test_reassert();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
